// File: rtl/inst_loader.sv
//------------------------------------------------------------------------------
// Module   : inst_loader
// Purpose  : Packs strobed program bytes into 32-bit little-endian words and
//            writes them to instruction RAM while holding the CPU in reset.
//            Optional define LOADER_CHECKSUM_EN adds a running XOR checksum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_loaded,
    output logic              overrun
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_FULL    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t     r_state;
    logic [1:0] r_lane;
    logic       r_bv_q;
    logic       r_flush;
    logic       w_stb;

    assign w_stb      = byte_valid & ~r_bv_q;
    assign byte_ready = (r_state == S_COLLECT);
    assign mem_we     = (r_state == S_WRITE);
    assign cpu_hold   = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lane       <= 2'd0;
            r_bv_q       <= 1'b0;
            r_flush      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            overrun      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= 8'd0;
`endif
        end else begin
            r_bv_q <= byte_valid;
            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        r_state      <= S_COLLECT;
                        r_lane       <= 2'd0;
                        r_flush      <= 1'b0;
                        mem_addr     <= '0;
                        mem_wdata    <= '0;
                        words_loaded <= '0;
                        overrun      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        checksum     <= 8'd0;
`endif
                    end
                end

                S_COLLECT: begin
                    if (w_stb) begin
                        mem_wdata[{r_lane, 3'b000} +: 8] <= byte_data;
                        r_lane <= r_lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum ^ byte_data;
`endif
                    end
                    // A byte arriving with the load_en fall is kept, then flushed.
                    if (w_stb && (r_lane == 2'd3)) begin
                        r_state <= S_WRITE;
                        r_flush <= ~load_en;
                    end else if (!load_en) begin
                        if (w_stb || (r_lane != 2'd0)) begin
                            r_state <= S_WRITE;
                            r_flush <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_WRITE: begin
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                    r_lane       <= 2'd0;
                    if (w_stb) begin
                        overrun <= 1'b1;
                    end
                    if (r_flush) begin
                        r_state <= S_IDLE;
                    end else if (mem_addr == C_LAST_ADDR) begin
                        r_state <= S_FULL;
                    end else begin
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= '0;
                        r_state   <= S_COLLECT;
                    end
                end

                S_FULL: begin
                    if (w_stb) begin
                        overrun <= 1'b1;
                    end
                    if (!load_en) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
